// File: rtl/aes_ctr_store.sv
// AES-CTR counter register with a handshake for an external slice-wise increment FSM.
// Define AES_CTR_STORE_SHADOW_EN to add a shadow counter copy that is checked every cycle.
module aes_ctr_store #(
    parameter int unsigned SliceSizeCtr = 16,
    parameter int unsigned NumSlicesCtr = 8,
    localparam int unsigned SliceIdxWidth = $clog2(NumSlicesCtr),
    localparam int unsigned CtrW = SliceSizeCtr * NumSlicesCtr
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     iv_load_i,
    input  logic [CtrW-1:0]          iv_i,
    input  logic                     incr_req_i,
    output logic                     incr_ack_o,
    output logic [CtrW-1:0]          ctr_o,
    output logic                     incr_o,
    input  logic                     ready_i,
    input  logic [SliceIdxWidth-1:0] ctr_slice_idx_i,
    output logic [SliceSizeCtr-1:0]  ctr_slice_o,
    input  logic [SliceSizeCtr-1:0]  ctr_slice_i,
    input  logic                     ctr_we_i,
    output logic                     err_o
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone, StError} state_e;

    state_e                                    state_q, state_d;
    logic [NumSlicesCtr-1:0][SliceSizeCtr-1:0] ctr_q, ctr_d;
    logic [SliceIdxWidth-1:0]                  exp_idx_q, exp_idx_d;
    logic                                      load_en, wr_en, incr, ack;
    logic                                      last_idx;
    logic                                      integ_err;

    assign last_idx = (ctr_slice_idx_i == SliceIdxWidth'(NumSlicesCtr - 1));

`ifdef AES_CTR_STORE_SHADOW_EN
    logic [NumSlicesCtr-1:0][SliceSizeCtr-1:0] shadow_q, shadow_d;

    // Shadow applies the same load/write to its own copy, so a flipped bit in either diverges.
    always_comb begin
        shadow_d = shadow_q;
        if (load_en) begin
            shadow_d = iv_i;
        end else if (wr_en) begin
            shadow_d[ctr_slice_idx_i] = ctr_slice_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign integ_err = (shadow_q != ctr_q);
`else
    assign integ_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        exp_idx_d = exp_idx_q;
        load_en   = 1'b0;
        wr_en     = 1'b0;
        incr      = 1'b0;
        ack       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ctr_we_i) begin
                    state_d = StError;
                end else if (iv_load_i) begin
                    load_en = 1'b1;
                end else if (incr_req_i && ready_i) begin
                    incr      = 1'b1;
                    exp_idx_d = '0;
                    state_d   = StBusy;
                end
            end
            StBusy: begin
                if (iv_load_i) begin
                    state_d = StError;
                end else if (ctr_we_i) begin
                    if (ctr_slice_idx_i != exp_idx_q) begin
                        state_d = StError;
                    end else begin
                        wr_en     = 1'b1;
                        exp_idx_d = last_idx ? '0 : exp_idx_q + SliceIdxWidth'(1);
                        if (last_idx) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (iv_load_i || ctr_we_i) begin
                    state_d = StError;
                end else if (ready_i) begin
                    ack     = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StError;
        endcase

        if (integ_err) begin
            state_d = StError;
            load_en = 1'b0;
            wr_en   = 1'b0;
            incr    = 1'b0;
            ack     = 1'b0;
        end
    end

    always_comb begin
        ctr_d = ctr_q;
        if (load_en) begin
            ctr_d = iv_i;
        end else if (wr_en) begin
            ctr_d[ctr_slice_idx_i] = ctr_slice_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            ctr_q     <= '0;
            exp_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            ctr_q     <= ctr_d;
            exp_idx_q <= exp_idx_d;
        end
    end

    // Gated so the combinational strobes drop as soon as reset asserts.
    assign incr_o      = incr & ~rst_i;
    assign incr_ack_o  = ack & ~rst_i;
    assign err_o       = (state_q == StError);
    assign ctr_o       = ctr_q;
    assign ctr_slice_o = ctr_q[ctr_slice_idx_i];

endmodule

// File: tb/tb_aes_ctr_store.sv
// Self-checking bench for aes_ctr_store; the bench itself plays the slice increment FSM.
module tb_aes_ctr_store;
    localparam int unsigned SliceSizeCtr = 16;
    localparam int unsigned NumSlicesCtr = 8;
    localparam int unsigned CtrW = SliceSizeCtr * NumSlicesCtr;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    iv_load;
    logic [CtrW-1:0]         iv;
    logic                    incr_req;
    logic                    incr_ack;
    logic [CtrW-1:0]         ctr;
    logic                    incr;
    logic                    ready;
    logic [2:0]              slice_idx;
    logic [SliceSizeCtr-1:0] slice_rd;
    logic [SliceSizeCtr-1:0] slice_wr;
    logic                    we;
    logic                    err;

    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    logic [CtrW-1:0] sb_q[$];

    always #5 clk = ~clk;

    aes_ctr_store #(
        .SliceSizeCtr(SliceSizeCtr),
        .NumSlicesCtr(NumSlicesCtr)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .iv_load_i      (iv_load),
        .iv_i           (iv),
        .incr_req_i     (incr_req),
        .incr_ack_o     (incr_ack),
        .ctr_o          (ctr),
        .incr_o         (incr),
        .ready_i        (ready),
        .ctr_slice_idx_i(slice_idx),
        .ctr_slice_o    (slice_rd),
        .ctr_slice_i    (slice_wr),
        .ctr_we_i       (we),
        .err_o          (err)
    );

    task automatic check_eq(input string tag, input logic [CtrW-1:0] got,
                            input logic [CtrW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset;
        #2;
        rst = 1'b1;
        iv_load = 1'b0;
        we = 1'b0;
        incr_req = 1'b1;
        ready = 1'b1;
        #1;
        check_eq("rst_ctr", ctr, '0);
        check_eq("rst_err", err, 1'b0);
        check_eq("rst_incr", incr, 1'b0);
        check_eq("rst_ack", incr_ack, 1'b0);
        step;
        step;
        rst = 1'b0;
        incr_req = 1'b0;
        sb_q.delete();
    endtask

    task automatic load_iv(input logic [CtrW-1:0] v);
        step;
        iv_load = 1'b1;
        iv = v;
        step;
        iv_load = 1'b0;
        #1;
        check_eq("load", ctr, v);
    endtask

    // Slice FSM model: ripple the +1 through slices 0..7, one write per cycle.
    task automatic run_slices(input logic [CtrW-1:0] start, input int acc);
        logic [SliceSizeCtr:0] sum;
        logic                  carry;
        logic [CtrW-1:0]       exp;
        bit                    got;
        carry = 1'b1;
        for (int k = 0; k < NumSlicesCtr; k++) begin
            step;
            ready = 1'b0;
            we = 1'b0;
            slice_idx = 3'(k);
            #1;
            check_eq("slice_rd", slice_rd, start[SliceSizeCtr*k +: SliceSizeCtr]);
            check_eq("busy_no_incr", incr, 1'b0);
            sum = {1'b0, slice_rd} + {{SliceSizeCtr{1'b0}}, carry};
            slice_wr = sum[SliceSizeCtr-1:0];
            carry = sum[SliceSizeCtr];
            we = 1'b1;
        end
        step;
        we = 1'b0;
        ready = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 4; t++) begin
            #1;
            if (incr_ack) begin
                got = 1'b1;
                break;
            end
            step;
        end
        check_eq("ack_seen", got, 1'b1);
        exp = sb_q.pop_front();
        if (got) begin
            check_eq("latency", cyc - acc, 9);
            check_eq("ack_no_incr", incr, 1'b0);
            check_eq("ctr_after_ack", ctr, exp);
            check_eq("err_after_ack", err, 1'b0);
        end
        step;
        incr_req = 1'b0;
        #1;
        check_eq("ack_pulse", incr_ack, 1'b0);
    endtask

    task automatic request_and_run(input logic [CtrW-1:0] start);
        incr_req = 1'b1;
        ready = 1'b1;
        #1;
        check_eq("accept", incr, 1'b1);
        sb_q.push_back(start + 1'b1);
        run_slices(start, cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [CtrW-1:0] v;
        logic [CtrW-1:0] forced;
        bit              any_out;
        rst = 1'b0;
        iv_load = 1'b0;
        iv = '0;
        incr_req = 1'b0;
        ready = 1'b1;
        slice_idx = '0;
        slice_wr = '0;
        we = 1'b0;

        // Basic increment with carry out of slice 0
        do_reset;
        load_iv(128'h0000_FFFF);
        request_and_run(128'h0000_FFFF);
        check_eq("basic_val", ctr, 128'h1_0000);

        // Full wrap of all-ones
        load_iv({CtrW{1'b1}});
        request_and_run({CtrW{1'b1}});
        check_eq("wrap_err", err, 1'b0);

        // Random value, two back-to-back increments
        v = {$urandom, $urandom, $urandom, $urandom};
        load_iv(v);
        request_and_run(v);
        request_and_run(v + 1'b1);
        check_eq("rand_two", ctr, v + 2'd2);

        // Load and request in the same cycle: load wins, request served afterwards
        v = 128'h0123_4567_89AB_CDEF_0000_0000_FFFF_FFFF;
        step;
        iv_load = 1'b1;
        iv = v;
        incr_req = 1'b1;
        ready = 1'b1;
        #1;
        check_eq("load_beats_req", incr, 1'b0);
        step;
        iv_load = 1'b0;
        #1;
        check_eq("load_same_cyc", ctr, v);
        request_and_run(v);

        // Write while idle is an error; later requests are ignored
        do_reset;
        step;
        we = 1'b1;
        #1;
        check_eq("idle_we_pre", err, 1'b0);
        step;
        we = 1'b0;
        #1;
        check_eq("idle_we_err", err, 1'b1);
        incr_req = 1'b1;
        ready = 1'b1;
        any_out = 1'b0;
        for (int t = 0; t < 5; t++) begin
            step;
            #1;
            any_out = any_out | incr | incr_ack;
        end
        check_eq("err_no_serve", any_out, 1'b0);
        incr_req = 1'b0;
        v = ctr;
        iv_load = 1'b1;
        iv = 128'hDEAD;
        step;
        iv_load = 1'b0;
        #1;
        check_eq("err_load_ignored", ctr, v);
        check_eq("err_sticky", err, 1'b1);

        // Out-of-order slice write in BUSY
        do_reset;
        v = 128'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_1111_2222;
        load_iv(v);
        incr_req = 1'b1;
        ready = 1'b1;
        #1;
        check_eq("oo_accept", incr, 1'b1);
        step;
        ready = 1'b0;
        slice_idx = 3'd0;
        slice_wr = 16'hABCD;
        we = 1'b1;
        step;
        slice_idx = 3'd2;
        slice_wr = 16'h1234;
        #1;
        check_eq("oo_pre_err", err, 1'b0);
        step;
        we = 1'b0;
        #1;
        check_eq("oo_err", err, 1'b1);
        check_eq("oo_ctr_held", ctr, {v[CtrW-1:16], 16'hABCD});
        incr_req = 1'b0;

        // Reset in the middle of an increment abandons it
        do_reset;
        load_iv(128'h5555);
        incr_req = 1'b1;
        ready = 1'b1;
        #1;
        check_eq("mid_accept", incr, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step;
            ready = 1'b0;
            slice_idx = 3'(k);
            slice_wr = 16'h7777;
            we = 1'b1;
        end
        #2;
        rst = 1'b1;
        #1;
        check_eq("mid_rst_ctr", ctr, '0);
        check_eq("mid_rst_ack", incr_ack, 1'b0);
        we = 1'b0;
        incr_req = 1'b0;
        step;
        rst = 1'b0;
        ready = 1'b1;
        any_out = 1'b0;
        for (int t = 0; t < 10; t++) begin
            step;
            #1;
            any_out = any_out | incr_ack | err;
        end
        check_eq("mid_rst_quiet", any_out, 1'b0);

        // Corrupt one counter bit directly
        do_reset;
        load_iv(128'h0F0F);
        step;
        forced = ctr ^ 128'h20;
        force dut.ctr_q = forced;
        step;
        #1;
`ifdef AES_CTR_STORE_SHADOW_EN
        check_eq("shadow_err", err, 1'b1);
`else
        check_eq("no_shadow_err", err, 1'b0);
`endif
        release dut.ctr_q;
        do_reset;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_ctr_store.md
AES_CTR_STORE -- requirements
Module: aes_ctr_store

Interface
REQ-001 SHALL have parameter SliceSizeCtr, default 16: counter slice width in bits.
REQ-002 SHALL have parameter NumSlicesCtr, default 8: slices per counter; SliceIdxWidth = clog2(NumSlicesCtr) = 3; counter width CtrW = SliceSizeCtr*NumSlicesCtr = 128.
REQ-003 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port iv_load_i  input  1  load iv_i into counter register.
REQ-006 SHALL have port iv_i  input  CtrW  initial counter value.
REQ-007 SHALL have port incr_req_i  input  1  upstream increment request, held until ack.
REQ-008 SHALL have port incr_ack_o  output  1  one-cycle increment-complete pulse.
REQ-009 SHALL have port ctr_o  output  CtrW  current counter value.
REQ-010 SHALL have port incr_o  output  1  increment command to slice FSM.
REQ-011 SHALL have port ready_i  input  1  slice FSM idle.
REQ-012 SHALL have port ctr_slice_idx_i  input  SliceIdxWidth  slice index from FSM.
REQ-013 SHALL have port ctr_slice_o  output  SliceSizeCtr  counter slice selected by ctr_slice_idx_i.
REQ-014 SHALL have port ctr_slice_i  input  SliceSizeCtr  updated slice from FSM.
REQ-015 SHALL have port ctr_we_i  input  1  write ctr_slice_i at ctr_slice_idx_i.
REQ-016 SHALL have port err_o  output  1  sticky protocol/integrity error.

Function
REQ-017 Slice k SHALL be ctr_q[SliceSizeCtr*k +: SliceSizeCtr], slice 0 least significant; ctr_slice_o combinational from ctr_slice_idx_i.
REQ-018 States SHALL be IDLE, BUSY, DONE, ERROR; ctr_o = ctr_q always.
REQ-019 IDLE: iv_load_i loads iv_i next edge and suppresses incr_o that cycle (load beats request).
REQ-020 IDLE: incr_req_i && ready_i && !iv_load_i SHALL assert incr_o combinationally for that cycle, clear expected-index counter exp_idx to 0, go BUSY.
REQ-021 BUSY: each ctr_we_i SHALL write ctr_slice_i into slice ctr_slice_idx_i and increment exp_idx (wraps modulo NumSlicesCtr); write of index NumSlicesCtr-1 SHALL go DONE.
REQ-022 DONE: when ready_i=1 SHALL pulse incr_ack_o for one cycle and return to IDLE; else stay DONE.
REQ-023 Accept-to-ack latency SHALL be NumSlicesCtr+1 cycles with a compliant slice FSM (9 for defaults).
REQ-024 Counter wrap: all-ones incremented SHALL yield all-zeros, no error, no flag.
REQ-025 Go ERROR on: ctr_we_i in IDLE or DONE; ctr_slice_idx_i != exp_idx with ctr_we_i in BUSY; iv_load_i in BUSY or DONE.
REQ-026 ERROR: terminal until reset; err_o=1; incr_o, incr_ack_o=0; writes and loads ignored; ctr_q held.
REQ-027 incr_ack_o, incr_o SHALL never assert in the same cycle.

Reset
REQ-028 rst_i asserted SHALL immediately set state IDLE, ctr_q=0, exp_idx=0, err_o=0, incr_o=0, incr_ack_o=0, ctr_o=0.
REQ-029 Reset mid-BUSY SHALL abandon the increment, no ack issued, counter zeroed.

Configuration
REQ-030 Macro AES_CTR_STORE_SHADOW_EN defined: SHALL keep a shadow copy of ctr_q updated identically and compare every cycle; mismatch SHALL go ERROR next edge.
REQ-031 Macro undefined: no shadow register, no comparison; all other behaviour identical.

Verification
REQ-032 Reset, load iv_i=0x0...0_0000_FFFF, request incr -> incr_o 1 cycle, 8 writes, incr_ack_o 9 cycles after accept, ctr_o=0x0...1_0000.
REQ-033 Load all-ones, incr -> ctr_o=0 after ack, err_o=0.
REQ-034 ctr_we_i=1 while IDLE -> err_o=1 next cycle, later incr_req_i gets no incr_o or ack.
REQ-035 In BUSY write idx 2 when exp_idx=1 -> ERROR, ctr_q unchanged from before bad write.
REQ-036 iv_load_i and incr_req_i same IDLE cycle -> iv loaded, incr_o=0; request served next cycle.
REQ-037 With AES_CTR_STORE_SHADOW_EN, force one ctr_q bit -> err_o=1 next cycle; without macro -> err_o stays 0.
